// File: rtl/hazard_pkg.sv
// Shared types for the decode-stage hazard controller.
// Holds FSM states, scoreboard entry layout and the hit helper.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN,
    STALL,
    FLUSH,
    HALT
  } state_e;

  typedef struct packed {
    logic [2:0] sel;
    logic       wr;
  } sb_ent_t;

  localparam sb_ent_t BUBBLE = '{sel: 3'd0, wr: 1'b0};

  function automatic logic sb_hit(
    input sb_ent_t    e,
    input logic [2:0] r
  );
    return e.wr && (e.sel == r);
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Decode-side bundle between the pipeline and hazard_ctrl.
// master = pipeline, slave = controller.
interface hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             id_valid;
  logic [2:0]       id_src1_sel;
  logic             id_src1_rd;
  logic [2:0]       id_src2_sel;
  logic             id_src2_rd;
  logic [2:0]       id_dst_sel;
  logic             id_dst_wr;
  logic             id_halt;
  logic             br_taken;
  logic             stall;
  logic             nop_mech;
  logic             flush_ifid;
  logic             halted;
  logic [CNT_W-1:0] stall_cycles;
  logic             err;

  modport master (
    output id_valid, id_src1_sel, id_src1_rd,
    output id_src2_sel, id_src2_rd,
    output id_dst_sel, id_dst_wr,
    output id_halt, br_taken,
    input  stall, nop_mech, flush_ifid,
    input  halted, stall_cycles, err
  );

  modport slave (
    input  id_valid, id_src1_sel, id_src1_rd,
    input  id_src2_sel, id_src2_rd,
    input  id_dst_sel, id_dst_wr,
    input  id_halt, br_taken,
    output stall, nop_mech, flush_ifid,
    output halted, stall_cycles, err
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Two-entry destination tracker for the EX and MEM slots.
// Reports source hits and whether both slots are drained.
module hazard_scoreboard
  import hazard_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  sb_ent_t    ent_i,
  input  logic [2:0] src1_i,
  input  logic [2:0] src2_i,
  output logic       hit1_o,
  output logic       hit2_o,
  output logic       drained_o
);

  sb_ent_t sb0_q;
  sb_ent_t sb1_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sb0_q <= BUBBLE;
      sb1_q <= BUBBLE;
    end else begin
      sb0_q <= ent_i;
      sb1_q <= sb0_q;
    end
  end

  assign hit1_o = sb_hit(sb0_q, src1_i)
                | sb_hit(sb1_q, src1_i);
  assign hit2_o = sb_hit(sb0_q, src2_i)
                | sb_hit(sb1_q, src2_i);
  assign drained_o = ~sb0_q.wr & ~sb1_q.wr;

endmodule

// File: rtl/hazard_ctrl.sv
// Decode-stage sequencing: RAW stalls, branch flush, halt drain.
// Also keeps a saturating stall counter and sticky timeout error.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int FLUSH_CYC = 2,
  parameter int MAX_STALL = 3,
  parameter int CNT_W     = 16
) (
  input logic         clk,
  input logic         rst,
  hazard_ctrl_if.slave hz
);

  state_e           state_q, state_d;
  logic [1:0]       fcnt_q, fcnt_d;
  logic [CNT_W-1:0] scnt_q, scnt_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic             err_q, err_d;
  logic             halted_q, halted_d;

  logic    hit1, hit2, drained;
  logic    hazard, issue, hz_stall;
  logic    stall, nop, flush;
  sb_ent_t ent;

  assign hazard = hz.id_valid
    & ((hz.id_src1_rd & hit1)
     | (hz.id_src2_rd & hit2));

  assign ent = issue
    ? '{sel: hz.id_dst_sel, wr: hz.id_dst_wr}
    : BUBBLE;

  hazard_scoreboard u_sb (
    .clk      (clk),
    .rst      (rst),
    .ent_i    (ent),
    .src1_i   (hz.id_src1_sel),
    .src2_i   (hz.id_src2_sel),
    .hit1_o   (hit1),
    .hit2_o   (hit2),
    .drained_o(drained)
  );

  always_comb begin
    state_d  = state_q;
    fcnt_d   = fcnt_q;
    stall    = 1'b0;
    nop      = 1'b0;
    flush    = 1'b0;
    issue    = 1'b0;
    hz_stall = 1'b0;
    unique case (state_q)
      RUN, STALL: begin
        if (hz.br_taken) begin
          flush   = 1'b1;
          nop     = 1'b1;
          fcnt_d  = 2'(FLUSH_CYC - 1);
          state_d = (FLUSH_CYC == 1) ? RUN : FLUSH;
        end else if (hazard) begin
          stall    = 1'b1;
          nop      = 1'b1;
          hz_stall = 1'b1;
          state_d  = STALL;
        end else begin
          issue   = hz.id_valid;
          state_d = (hz.id_valid & hz.id_halt)
                  ? HALT : RUN;
        end
      end
      FLUSH: begin
        flush = 1'b1;
        nop   = 1'b1;
        if (hz.br_taken) begin
          fcnt_d = 2'(FLUSH_CYC - 1);
        end else if (fcnt_q <= 2'd1) begin
          fcnt_d  = 2'd0;
          state_d = RUN;
        end else begin
          fcnt_d = fcnt_q - 2'd1;
        end
      end
      HALT: begin
        stall = 1'b1;
        nop   = 1'b1;
      end
      default: state_d = RUN;
    endcase
  end

  // stalled cycles only occur while staying in (or entering) STALL
  assign scnt_d = hz_stall
    ? scnt_q + CNT_W'(1) : '0;
  assign err_d = err_q
    | (scnt_q == CNT_W'(MAX_STALL));
  assign cyc_d = (hz_stall & ~(&cyc_q))
    ? cyc_q + CNT_W'(1) : cyc_q;
  assign halted_d = halted_q
    | ((state_q == HALT) & drained);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= RUN;
      fcnt_q   <= 2'd0;
      scnt_q   <= '0;
      cyc_q    <= '0;
      err_q    <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      fcnt_q   <= fcnt_d;
      scnt_q   <= scnt_d;
      cyc_q    <= cyc_d;
      err_q    <= err_d;
      halted_q <= halted_d;
    end
  end

  assign hz.stall        = stall & ~rst;
  assign hz.nop_mech     = nop & ~rst;
  assign hz.flush_ifid   = flush & ~rst;
  assign hz.halted       = halted_q;
  assign hz.stall_cycles = cyc_q;
  assign hz.err          = err_q;

endmodule
